// File: rtl/imem_boot_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_boot_loader : loads a length-prefixed little-endian program image from
// a byte stream into instruction memory, then releases the core from reset.
// Optional trailing XOR checksum is enabled by defining BOOT_CSUM_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          MAX_WORDS     = 64,
  parameter int          RELEASE_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam int DLY_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
`ifdef BOOT_CSUM_EN
    CSUM,
`endif
    RUN_WAIT,
    RUN,
    ERR
  } state_t;

  state_t            state;
  logic [15:0]       n_words;
  logic [15:0]       word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [DLY_W-1:0]  dly_cnt;
`ifdef BOOT_CSUM_EN
  logic [7:0]        csum;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = rx_valid & rx_ready;
  assign len_full  = {rx_data, n_words[7:0]};
  assign last_word = (word_idx == n_words - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LEN0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0;
      core_rst   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      n_words    <= 16'h0;
      word_idx   <= 16'h0;
      byte_idx   <= 2'd0;
      word_buf   <= 24'h0;
      dly_cnt    <= '0;
`ifdef BOOT_CSUM_EN
      csum       <= 8'h0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        LEN0: begin
          // rx_ready is registered, so it rises on the first edge after reset
          rx_ready <= 1'b1;
          if (accept) begin
            n_words[7:0] <= rx_data;
            state        <= LEN1;
          end
        end

        LEN1: begin
          if (accept) begin
            n_words[15:8] <= rx_data;
            if (len_full == 16'd0 || len_full > 16'(MAX_WORDS)) begin
              state    <= ERR;
              error    <= 1'b1;
              rx_ready <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
`ifdef BOOT_CSUM_EN
            csum <= csum ^ rx_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= BASE_ADDR + {14'h0, word_idx, 2'b00};
                imem_wdata <= {rx_data, word_buf};
                word_idx   <= word_idx + 16'd1;
                if (last_word) begin
`ifdef BOOT_CSUM_EN
                  state    <= CSUM;
`else
                  state    <= RUN_WAIT;
                  rx_ready <= 1'b0;
`endif
                end
              end
            endcase
          end
        end

`ifdef BOOT_CSUM_EN
        CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state <= RUN_WAIT;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        RUN_WAIT: begin
          if (dly_cnt == DLY_W'(RELEASE_DELAY - 1)) begin
            state    <= RUN;
            core_rst <= 1'b1;
            done     <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end

        RUN: begin
        end

        ERR: begin
        end

        default: begin
          state    <= ERR;
          error    <= 1'b1;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_boot_loader : randomized and directed byte streams checked against
// a queue-based reference model of the image format. Rev 1.0
// ----------------------------------------------------------------------------
module tb_imem_boot_loader;

  localparam logic [31:0] BASE_ADDR     = 32'h0000_0000;
  localparam int          MAX_WORDS     = 64;
  localparam int          RELEASE_DELAY = 4;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  imem_boot_loader #(
    .BASE_ADDR     (BASE_ADDR),
    .MAX_WORDS     (MAX_WORDS),
    .RELEASE_DELAY (RELEASE_DELAY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(negedge clk) begin
    if (rst && imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
    check({tag, "_imem_we"},    32'(imem_we),    32'd0);
    check({tag, "_imem_addr"},  imem_addr,       BASE_ADDR);
    check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    check({tag, "_core_rst"},   32'(core_rst),   32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 3));
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic append_csum(input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stim_q.size(); i++) x ^= stim_q[i];
`ifdef BOOT_CSUM_EN
    stim_q.push_back(x ^ flip);
`endif
  endtask

  task automatic make_stream(input logic [15:0] n, input int n_words, input logic [7:0] flip);
    stim_q.delete();
    stim_q.push_back(n[7:0]);
    stim_q.push_back(n[15:8]);
    for (int i = 0; i < 4 * n_words; i++) stim_q.push_back(8'($urandom));
    append_csum(flip);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Reference: decode the image from stim_q, predict writes and outcome, then drive and compare.
  task automatic do_load(input string tag, input int mode);
    logic [15:0] n;
    logic [7:0]  x;
    bit          len_bad;
    bit          csum_ok;
    int          n_send;
    int          n_cmp;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    n       = {stim_q[1], stim_q[0]};
    len_bad = (n == 16'd0) || (int'(n) > MAX_WORDS);
    x       = 8'h00;
    csum_ok = 1'b1;
    if (!len_bad) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_addr.push_back(BASE_ADDR + 32'(4 * i));
        exp_data.push_back({stim_q[2+4*i+3], stim_q[2+4*i+2], stim_q[2+4*i+1], stim_q[2+4*i]});
        for (int j = 0; j < 4; j++) x ^= stim_q[2+4*i+j];
      end
`ifdef BOOT_CSUM_EN
      csum_ok = (stim_q[2+4*int'(n)] == x);
`endif
    end
    n_send = len_bad ? 2 : stim_q.size();

    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < n_send; i++) send_byte(stim_q[i], gap_for(mode));

    check({tag, "_rdy_after_last"}, 32'(rx_ready), 32'd0);
    if (len_bad || !csum_ok) begin
      check({tag, "_err_now"},  32'(error),    32'd1);
      check({tag, "_crst_now"}, 32'(core_rst), 32'd0);
      repeat (RELEASE_DELAY + 4) @(negedge clk);
      check({tag, "_err_hold"},  {29'd0, error, core_rst, done}, 32'h4);
      check({tag, "_rdy_hold"},  32'(rx_ready), 32'd0);
    end else begin
      // core_rst rises RELEASE_DELAY edges after the edge that took the last byte
      check({tag, "_crst_wait"}, 32'(core_rst), 32'd0);
      for (int i = 1; i < RELEASE_DELAY; i++) begin
        @(negedge clk);
        check({tag, "_crst_wait"}, 32'(core_rst), 32'd0);
      end
      @(negedge clk);
      check({tag, "_released"}, {29'd0, core_rst, done, error}, 32'h6);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      repeat (4) @(negedge clk);
      rx_valid = 1'b0;
      check({tag, "_run_hold"}, {29'd0, core_rst, done, rx_ready}, 32'h6);
    end

    check({tag, "_n_writes"}, 32'(wr_addr_q.size()), 32'(exp_addr.size()));
    n_cmp = (wr_addr_q.size() < exp_addr.size()) ? wr_addr_q.size() : exp_addr.size();
    for (int i = 0; i < n_cmp; i++) begin
      check({tag, "_addr"}, wr_addr_q[i], exp_addr[i]);
      check({tag, "_data"}, wr_data_q[i], exp_data[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] n;
    int          r;
    logic [7:0]  flip;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("idle", {28'd0, rx_ready, core_rst, done, error}, 32'h8);
      @(negedge clk);
    end

    stim_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    append_csum(8'h00);
    do_load("plan_ok", 0);
    check("plan_word0", wr_data_q[0], 32'h0050_0513);
    check("plan_word1", wr_data_q[1], 32'h00A0_0593);
    check("plan_addr1", wr_addr_q[1], 32'h0000_0004);
    reset_dut();

`ifdef BOOT_CSUM_EN
    stim_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    append_csum(8'h01);
    do_load("plan_badcsum", 0);
    reset_dut();
`endif

    stim_q = '{8'h00, 8'h00};
    do_load("len_zero", 0);
    reset_dut();
    stim_q = '{8'h41, 8'h00};
    do_load("len_65", 0);
    reset_dut();
    stim_q = '{8'h40, 8'h00};
    append_csum(8'h00);
    for (int i = 0; i < 4 * MAX_WORDS; i++) stim_q.insert(2, 8'($urandom));
    stim_q = stim_q[0:2+4*MAX_WORDS-1];
    append_csum(8'h00);
    do_load("len_max", 0);
    reset_dut();

    stim_q = '{8'h02, 8'h00, 8'hAA, 8'hBB};
    for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i], 0);
    #2 rst = 1'b0;
    #1 check_reset_vals("midload_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    stim_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    append_csum(8'h00);
    do_load("after_rst", 0);
    check("after_rst_word0", wr_data_q[0], 32'h0050_0513);
    check("after_rst_addr0", wr_addr_q[0], BASE_ADDR);
    reset_dut();

    stim_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    append_csum(8'h00);
    do_load("toggle", 1);
    check("toggle_word", wr_data_q[0], 32'hDEAD_BEEF);
    reset_dut();

    for (int it = 0; it < 12; it++) begin
      r    = int'($urandom_range(0, 9));
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if (r == 0) begin
        make_stream(16'd0, 0, flip);
      end else if (r == 1) begin
        n = 16'(MAX_WORDS + 1 + int'($urandom_range(0, 2000)));
        make_stream(n, 0, flip);
      end else begin
        n = 16'($urandom_range(1, 6));
        make_stream(n, int'(n), flip);
      end
      do_load("random", int'($urandom_range(0, 2)));
      reset_dut();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
